// File: rtl/silife_spi_pkg.sv
// silife_spi_pkg: shared SPI word width, arbiter state encoding and MAX7219 register addresses
package silife_spi_pkg;
  localparam int SPI_WORD_W = 16;
  typedef enum logic [2:0] {IDLE, LOAD, GUARD, WAIT, GAP} arb_state_t;
  localparam logic [3:0] MAX_NOOP      = 4'h0;
  localparam logic [3:0] MAX_DIGIT0    = 4'h1;
  localparam logic [3:0] MAX_INTENSITY = 4'hA;
  localparam logic [3:0] MAX_SCANLIMIT = 4'hB;
  localparam logic [3:0] MAX_SHUTDOWN  = 4'hC;
  localparam logic [3:0] MAX_TEST      = 4'hF;
endpackage

// File: rtl/silife_rr_picker.sv
// silife_rr_picker: round-robin winner search starting just after the last owner
module silife_rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic [IW-1:0] o_idx
);
  logic found;
  always_comb begin
    o_win = '0;
    o_idx = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++)
      if (!found && i_req[(int'(i_ptr) + i) % N]) begin
        o_win[(int'(i_ptr) + i) % N] = 1'b1;
        o_idx = IW'((int'(i_ptr) + i) % N);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/silife_spi_arbiter.sv
// silife_spi_arbiter: shares one SPI master among requesters, framing each owner's words under one CS-low window
module silife_spi_arbiter
  import silife_spi_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int CS_GAP = 2,
  parameter int WORD_W = SPI_WORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*WORD_W-1:0] i_word,
  input  logic [N_REQ-1:0]        i_last,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_cs,
  output logic [WORD_W-1:0]       o_spi_word,
  output logic                    o_spi_start,
  input  logic                    i_spi_busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(CS_GAP + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CS_GAP - 1);
  arb_state_t state, state_d;
  logic [IW-1:0] owner, owner_d, ptr, ptr_d, win_idx;
  logic [N_REQ-1:0] win, grant_d, ack_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [WORD_W-1:0] word_d;
  logic last_q, last_d, cs_d, start_d;
  silife_rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .i_req(i_req),
    .i_ptr(ptr),
    .o_win(win),
    .o_idx(win_idx)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= IW'(N_REQ - 1);
      cnt         <= '0;
      last_q      <= 1'b0;
      o_cs        <= 1'b1;
      o_grant     <= '0;
      o_ack       <= '0;
      o_spi_start <= 1'b0;
      o_spi_word  <= '0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      last_q      <= last_d;
      o_cs        <= cs_d;
      o_grant     <= grant_d;
      o_ack       <= ack_d;
      o_spi_start <= start_d;
      o_spi_word  <= word_d;
    end
  always_comb begin
    state_d = state;
    owner_d = owner;
    ptr_d   = ptr;
    cnt_d   = '0;
    last_d  = last_q;
    cs_d    = o_cs;
    grant_d = o_grant;
    ack_d   = '0;
    start_d = 1'b0;
    word_d  = o_spi_word;
    case (state)
      // a master still draining a truncated word keeps us out of LOAD
      IDLE: if (|i_req && !i_spi_busy) begin
        grant_d = win;
        owner_d = win_idx;
        cs_d    = 1'b0;
        state_d = LOAD;
      end
      LOAD: if (i_req[owner]) begin
        word_d       = i_word[int'(owner)*WORD_W +: WORD_W];
        start_d      = 1'b1;
        ack_d[owner] = 1'b1;
        last_d       = i_last[owner];
        state_d      = GUARD;
      end else begin
        cs_d    = 1'b1;
        grant_d = '0;
        state_d = GAP;
      end
      GUARD: state_d = WAIT;
      WAIT: if (!i_spi_busy) begin
        state_d = last_q ? GAP : LOAD;
        cs_d    = last_q ? 1'b1 : o_cs;
        grant_d = last_q ? '0 : o_grant;
      end
      GAP: begin
        ptr_d   = owner;
        cnt_d   = (cnt == CNT_END) ? '0 : cnt + 1'b1;
        state_d = (cnt == CNT_END) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_silife_spi_arbiter.sv
// tb_silife_spi_arbiter: vector table plus frame sequences against a simple busy model of the SPI master
module tb_silife_spi_arbiter;
  localparam int T = 4;
  typedef struct {
    logic [1:0]  req;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [1:0]  grant;
    logic [15:0] word;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] i_req = '0;
  logic [31:0] i_word = '0;
  logic [1:0] i_last = '0;
  logic [1:0] o_ack, o_grant;
  logic o_cs, o_spi_start, busy;
  logic [15:0] o_spi_word;
  int bcnt = 0;
  int starts = 0;
  int checks = 0;
  int errors = 0;
  logic watch = 1'b0;
  logic viol = 1'b0;
  vec_t tbl[8];
  silife_spi_arbiter #(.N_REQ(2), .CS_GAP(2), .WORD_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_word(i_word),
    .i_last(i_last),
    .o_ack(o_ack),
    .o_grant(o_grant),
    .o_cs(o_cs),
    .o_spi_word(o_spi_word),
    .o_spi_start(o_spi_start),
    .i_spi_busy(busy)
  );
  always #5 clk = ~clk;
  assign busy = (bcnt != 0);
  always @(posedge clk) begin
    if (o_spi_start) bcnt <= T;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    if (o_spi_start) starts <= starts + 1;
  end
  always @(negedge clk)
    if (watch && (o_grant[1] || o_ack[1])) viol = 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic wait_start(output int c);
    c = 0;
    do begin @(negedge clk); c++; end while (!o_spi_start && c < 40);
    chk("start_seen", 32'(o_spi_start), 32'd1);
  endtask
  task automatic wait_cs_high(output int c);
    c = 0;
    do begin @(negedge clk); c++; end while (!o_cs && c < 40);
    chk("cs_rise", 32'(o_cs), 32'd1);
  endtask
  task automatic finish_gap();
    chk("gap_grant", 32'(o_grant), 32'd0);
    @(negedge clk);
    chk("gap_cs", 32'(o_cs), 32'd1);
    @(negedge clk);
  endtask
  task automatic run_vec(input vec_t v);
    int c;
    i_req = v.req;
    i_word = {v.w1, v.w0};
    i_last = 2'b11;
    wait_start(c);
    chk("latency", 32'(c), 32'd2);
    chk("grant", 32'(o_grant), 32'(v.grant));
    chk("ack", 32'(o_ack), 32'(v.grant));
    chk("word", 32'(o_spi_word), 32'(v.word));
    chk("cs_low", 32'(o_cs), 32'd0);
    i_req = '0;
    wait_cs_high(c);
    finish_gap();
  endtask
  initial begin
    int c, low, st0, hi;
    tbl[0] = '{2'b11, 16'h0C01, 16'h0A05, 2'b01, 16'h0C01};
    tbl[1] = '{2'b11, 16'h0B07, 16'h0A03, 2'b10, 16'h0A03};
    tbl[2] = '{2'b11, 16'h0101, 16'h0202, 2'b01, 16'h0101};
    tbl[3] = '{2'b01, 16'h0303, 16'h0404, 2'b01, 16'h0303};
    tbl[4] = '{2'b01, 16'h0F00, 16'h0F01, 2'b01, 16'h0F00};
    tbl[5] = '{2'b10, 16'h0505, 16'h0606, 2'b10, 16'h0606};
    tbl[6] = '{2'b10, 16'h0707, 16'h0808, 2'b10, 16'h0808};
    tbl[7] = '{2'b11, 16'h0909, 16'h0A0A, 2'b01, 16'h0909};
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_cs", 32'(o_cs), 32'd1);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_start", 32'(o_spi_start), 32'd0);
    chk("rst_word", 32'(o_spi_word), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    // two-word frame from requester 0
    st0 = starts;
    i_req = 2'b01; i_word = {16'h0, 16'h0F00}; i_last = 2'b00;
    wait_start(c);
    chk("f1_word0", 32'(o_spi_word), 32'h0F00);
    chk("f1_ack0", 32'(o_ack), 32'd1);
    i_word = {16'h0, 16'h0B07}; i_last = 2'b01;
    hi = 0; c = 0;
    do begin @(negedge clk); c++; if (o_cs) hi++; end while (!o_spi_start && c < 40);
    chk("start_seen", 32'(o_spi_start), 32'd1);
    chk("f1_s2s", 32'(c), 32'(T + 3));
    chk("f1_word1", 32'(o_spi_word), 32'h0B07);
    chk("f1_ack1", 32'(o_ack), 32'd1);
    chk("f1_cs_held", 32'(hi), 32'd0);
    i_req = '0;
    wait_cs_high(c);
    chk("f1_starts", 32'(starts - st0), 32'd2);
    finish_gap();
    // requester 1 arrives mid-frame and must wait for the gap
    i_req = 2'b01; i_word = {16'h0, 16'h00A1}; i_last = 2'b00;
    wait_start(c);
    i_req = 2'b11; i_word = {16'h1111, 16'h00A2}; i_last = 2'b10;
    watch = 1'b1;
    wait_start(c);
    chk("f3_word1", 32'(o_spi_word), 32'h00A2);
    i_word = {16'h1111, 16'h00A3}; i_last = 2'b11;
    wait_start(c);
    chk("f3_word2", 32'(o_spi_word), 32'h00A3);
    chk("f3_grant", 32'(o_grant), 32'd1);
    i_req = 2'b10;
    wait_cs_high(c);
    @(negedge clk);
    @(negedge clk);
    watch = 1'b0;
    chk("f3_no_intrude", 32'(viol), 32'd0);
    wait_start(c);
    chk("f3_next_grant", 32'(o_grant), 32'd2);
    chk("f3_next_ack", 32'(o_ack), 32'd2);
    chk("f3_next_word", 32'(o_spi_word), 32'h1111);
    i_req = '0;
    wait_cs_high(c);
    finish_gap();
    // owner abandons the frame after a non-last word
    i_req = 2'b01; i_word = {16'h0, 16'h0B01}; i_last = 2'b00;
    wait_start(c);
    i_req = '0;
    wait_cs_high(c);
    chk("f4_cs_rise_time", 32'(c), 32'(T + 3));
    chk("f4_grant", 32'(o_grant), 32'd0);
    st0 = starts;
    repeat (4) @(negedge clk);
    chk("f4_no_start", 32'(starts - st0), 32'd0);
    chk("f4_cs_idle", 32'(o_cs), 32'd1);
    // single-word frame from requester 1
    st0 = starts;
    low = 0; c = 0;
    i_req = 2'b10; i_word = {16'h0C01, 16'h0}; i_last = 2'b10;
    do begin
      @(negedge clk); c++;
      if (!o_cs) low++;
      if (o_spi_start) begin
        chk("f6_word", 32'(o_spi_word), 32'h0C01);
        chk("f6_grant", 32'(o_grant), 32'd2);
        i_req = '0;
      end
    end while (!(low > 0 && o_cs) && c < 40);
    chk("f6_cs_low_span", 32'(low), 32'(T + 3));
    chk("f6_starts", 32'(starts - st0), 32'd1);
    finish_gap();
    // asynchronous reset in the middle of a word
    i_req = 2'b10; i_word = {16'h0A0F, 16'h0}; i_last = 2'b10;
    wait_start(c);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    i_req = '0;
    #1;
    chk("f5_cs", 32'(o_cs), 32'd1);
    chk("f5_grant", 32'(o_grant), 32'd0);
    chk("f5_ack", 32'(o_ack), 32'd0);
    chk("f5_word", 32'(o_spi_word), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (T + 3) @(negedge clk);
    run_vec('{2'b11, 16'h5A5A, 16'hA5A5, 2'b01, 16'h5A5A});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
